// File: rtl/jas_planner_if.sv
// jas_planner_if
//   Bundles the command-side and controller-side signals of one planner.
//   Parameter W : width of command fields and parameter words.
//   Modports:
//     slave  - the planner itself (accepts commands, drives params/start)
//     master - the command source / controller model facing the planner
//   Signals:
//     cmd_valid/cmd_ready, cmd_steps/cmd_t0/cmd_tna/cmd_delta : command push
//     abort      : stop current move and flush the buffer
//     params     : {N, nn, t0, tna, delta} to the step controller
//     start      : move enable, finish : controller move-complete flag
//     busy       : planner not idle, moves_done : completed-move counter
//
// Handshake: a command is transferred on a rising clk edge where
// cmd_valid & cmd_ready are both high. cmd_ready depends only on buffer
// state, never on cmd_valid; the source holds the cmd_* fields stable while
// cmd_valid is high and not yet accepted.
interface jas_planner_if #(
  parameter int W = 32
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [W-1:0] cmd_steps;
  logic [W-1:0] cmd_t0;
  logic [W-1:0] cmd_tna;
  logic [W-1:0] cmd_delta;
  logic         abort;
  logic [W-1:0] params [0:4];
  logic         start;
  logic         finish;
  logic         busy;
  logic [15:0]  moves_done;

  modport slave (
    input  cmd_valid, cmd_steps, cmd_t0, cmd_tna, cmd_delta, abort, finish,
    output cmd_ready, params, start, busy, moves_done
  );

  modport master (
    output cmd_valid, cmd_steps, cmd_t0, cmd_tna, cmd_delta, abort, finish,
    input  cmd_ready, params, start, busy, moves_done
  );
endinterface

// File: rtl/jas_planner.sv
// jas_planner
//   Move-command planner/sequencer for one axis of the jerk/acceleration/speed
//   step controller. Buffers raw move commands, sanitises them, computes the
//   acceleration step count nn = min(ceil((t0-tna)/delta), N>>1) by repeated
//   subtraction, then drives params/start and waits for finish.
//   Ports:
//     clk       : system clock, rising edge
//     reset     : asynchronous, active-high reset
//     bus       : jas_planner_if.slave (command push, abort, params, start,
//                 finish, busy, moves_done)
//     dbg_state : current FSM state (IDLE=0, CALC=1, LOAD=2, RUN=3, DONE=4)
//   Configuration macro JAS_PLANNER_FIFO4_EN:
//     defined   -> 4-entry command FIFO
//     undefined -> single-entry command buffer
module jas_planner #(
  parameter int W = 32
) (
  input  logic             clk,
  input  logic             reset,
  jas_planner_if.slave     bus,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALC = 3'd1,
    S_LOAD = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  typedef struct packed {
    logic [W-1:0] steps;
    logic [W-1:0] t0;
    logic [W-1:0] tna;
    logic [W-1:0] delta;
  } cmd_t;

  state_t state, next_state;

  cmd_t cmd_in, head;
  logic empty, full, push, pop, flush;

  assign cmd_in = {bus.cmd_steps, bus.cmd_t0, bus.cmd_tna, bus.cmd_delta};

  // Abort beats everything: no push, no pop on the flush edge.
  assign flush = bus.abort;
  assign push  = bus.cmd_valid & bus.cmd_ready & ~flush;
  assign pop   = (state == S_IDLE) & ~empty & ~flush;
  assign bus.cmd_ready = ~full;

`ifdef JAS_PLANNER_FIFO4_EN
  cmd_t       mem [0:3];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;

  assign empty = (count == 3'd0);
  assign full  = (count == 3'd4);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end
`else
  cmd_t buf_q;
  logic buf_valid;

  assign empty = ~buf_valid;
  assign full  = buf_valid;
  assign head  = buf_q;

  // push needs an empty slot and pop needs a full one, so they never coincide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q     <= '0;
      buf_valid <= 1'b0;
    end else if (flush) begin
      buf_valid <= 1'b0;
    end else if (push) begin
      buf_q     <= cmd_in;
      buf_valid <= 1'b1;
    end else if (pop) begin
      buf_valid <= 1'b0;
    end
  end
`endif

  // Working registers for the move being planned.
  logic [W-1:0] n_r, t0_r, tna_r, delta_r, rem_r, cnt_r, cap_r;
  logic [W-1:0] tna_sane;
  logic         take_cmd, calc_done;

  assign tna_sane  = (head.tna > head.t0) ? head.t0 : head.tna;
  // A zero-step command is popped and silently dropped.
  assign take_cmd  = pop & (head.steps != '0);
  assign calc_done = (rem_r == '0) | (delta_r == '0) | (cnt_r == cap_r);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (take_cmd) next_state = S_CALC;
      S_CALC: if (calc_done) next_state = S_LOAD;
      S_LOAD: next_state = S_RUN;
      S_RUN:  if (bus.finish) next_state = S_DONE;
      S_DONE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    if (flush) next_state = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_r     <= '0;
      t0_r    <= '0;
      tna_r   <= '0;
      delta_r <= '0;
      rem_r   <= '0;
      cnt_r   <= '0;
      cap_r   <= '0;
    end else if (take_cmd) begin
      n_r     <= head.steps;
      t0_r    <= head.t0;
      tna_r   <= tna_sane;
      delta_r <= head.delta;
      rem_r   <= head.t0 - tna_sane;
      cnt_r   <= '0;
      cap_r   <= head.steps >> 1;
    end else if (state == S_CALC && !calc_done) begin
      // Saturating subtract gives the ceiling without a divider.
      rem_r <= (rem_r > delta_r) ? rem_r - delta_r : '0;
      cnt_r <= cnt_r + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 5; i++) bus.params[i] <= '0;
      bus.start      <= 1'b0;
      bus.moves_done <= '0;
    end else if (flush) begin
      bus.start <= 1'b0;
    end else if (state == S_LOAD) begin
      bus.params[0] <= n_r;
      bus.params[1] <= cnt_r;
      bus.params[2] <= t0_r;
      bus.params[3] <= tna_r;
      bus.params[4] <= delta_r;
      bus.start     <= 1'b1;
    end else if (state == S_DONE) begin
      bus.start      <= 1'b0;
      bus.moves_done <= bus.moves_done + 16'd1;
    end
  end

  assign bus.busy  = (state != S_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_jas_planner.sv
module tb_jas_planner;
  localparam int W = 32;
`ifdef JAS_PLANNER_FIFO4_EN
  localparam int QD = 4;
`else
  localparam int QD = 1;
`endif

  logic       clk;
  logic       reset;
  logic [2:0] dbg_state;

  jas_planner_if #(.W(W)) bus ();

  jas_planner #(.W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_moves = 16'd0;

  // expected {N, nn, t0, tna, delta}
  logic [5*W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic busy_d  = 1'b0;
  logic start_d = 1'b0;
  int   cyc     = 0;

  always @(negedge clk) begin
    logic [5*W-1:0] e;
    if (!reset) begin
      if (bus.busy && !busy_d) cyc = 0;
      else cyc++;
      if (bus.start && !start_d) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_start", 1, 0);
        end else begin
          e = exp_q.pop_front();
          for (int i = 0; i < 5; i++)
            chk($sformatf("param%0d", i), bus.params[i], e[(4-i)*W +: W]);
          chk("start_latency", cyc, e[3*W +: W] + 2);
        end
      end
      busy_d  = bus.busy;
      start_d = bus.start;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_cmd(input logic [W-1:0] n, t0, tna, delta,
                          input logic expect_run,
                          input logic [W-1:0] exp_nn, exp_tna);
    int waited = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_steps = n;
    bus.cmd_t0    = t0;
    bus.cmd_tna   = tna;
    bus.cmd_delta = delta;
    while (!bus.cmd_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.cmd_ready) begin
      chk("push_timeout", 0, 1);
    end else begin
      if (expect_run) exp_q.push_back({n, exp_nn, t0, exp_tna, delta});
      @(posedge clk);
    end
    #1 bus.cmd_valid = 1'b0;
  endtask

  // Offer a command for one edge only; it must be refused.
  task automatic offer_refused(input logic [W-1:0] n);
    @(negedge clk);
    chk("ready_full", bus.cmd_ready, 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_steps = n;
    bus.cmd_t0    = 32'd40;
    bus.cmd_tna   = 32'd10;
    bus.cmd_delta = 32'd3;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_start();
    int waited = 0;
    while (!bus.start && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.start) chk("start_timeout", 0, 1);
  endtask

  task automatic run_move();
    wait_start();
    repeat (2) @(negedge clk);
    chk("start_hold", bus.start, 1);
    bus.finish = 1'b1;
    @(posedge clk);
    #1 bus.finish = 1'b0;
    @(negedge clk);
    chk("start_at_finish_edge", bus.start, 1);
    @(negedge clk);
    exp_moves = exp_moves + 16'd1;
    chk("start_fall", bus.start, 0);
    chk("moves_done", bus.moves_done, exp_moves);
    chk("busy_after_done", bus.busy, 0);
  endtask

  // ---------------- directed stimulus ----------------
  logic [W-1:0] qn  [0:3] = '{32'd4, 32'd6, 32'd8, 32'd10};
  logic [W-1:0] qnn [0:3] = '{32'd2, 32'd3, 32'd4, 32'd4};

  initial begin
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_steps = '0;
    bus.cmd_t0    = '0;
    bus.cmd_tna   = '0;
    bus.cmd_delta = '0;
    bus.abort     = 1'b0;
    bus.finish    = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("rst_start", bus.start, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_moves", bus.moves_done, 0);
    chk("rst_ready", bus.cmd_ready, 1);
    chk("rst_state", dbg_state, 0);
    for (int i = 0; i < 5; i++) chk($sformatf("rst_param%0d", i), bus.params[i], 0);

    // basic move, nn limited by ramp
    push_cmd(100, 1000, 200, 100, 1, 8, 200);
    run_move();
    // nn capped at N>>1
    push_cmd(10, 1000, 100, 50, 1, 5, 100);
    run_move();
    // delta = 0
    push_cmd(20, 500, 100, 0, 1, 0, 100);
    run_move();
    // tna above t0 is clamped
    push_cmd(10, 100, 300, 7, 1, 0, 100);
    run_move();
    // zero-step command discarded, next one runs
    push_cmd(0, 10, 3, 1, 0, 0, 0);
    push_cmd(4, 10, 10, 1, 1, 0, 10);
    run_move();

    // queue while a move runs: t0=30, tna=10, delta=5 -> ramp of 4
    push_cmd(50, 100, 50, 10, 1, 5, 50);
    wait_start();
    for (int i = 0; i < QD; i++) push_cmd(qn[i], 30, 10, 5, 1, qnn[i], 10);
    offer_refused(32'd12);
    run_move();
    for (int i = 0; i < QD; i++) run_move();

    // abort during RUN with queued commands and a same-edge push
    push_cmd(50, 100, 50, 10, 1, 5, 50);
    wait_start();
    for (int i = 0; i < QD && i < 2; i++) push_cmd(qn[i], 30, 10, 5, 0, 0, 0);
    @(negedge clk);
    bus.abort     = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_steps = 32'd6;
    @(posedge clk);
    #1;
    bus.abort     = 1'b0;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("abort_start", bus.start, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_ready", bus.cmd_ready, 1);
    chk("abort_moves", bus.moves_done, exp_moves);
    chk("abort_param0", bus.params[0], 50);
    chk("abort_param1", bus.params[1], 5);
    repeat (20) @(negedge clk);
    chk("abort_idle", bus.busy, 0);
    // buffer must be empty: only this command runs next
    push_cmd(10, 1000, 100, 50, 1, 5, 100);
    run_move();

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d expected %0d", 1, 0);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
